// File: rtl/pq_op_sched.sv
// pq_op_sched: schedules enqueue, dequeue and read-modify-write requests
// onto a priority-queue command port, one queue command per cycle.
// Enq/deq are granted in a single cycle; an RMW issues a lookup, waits for
// the hit result, then commits an update or delete in its CHECK cycle.
// The fce_t/tuple_t record types live in package my_struct_s at the top of
// this file. Optional macro PQ_SCHED_STATS_EN enables the stat_* counters;
// without it the stat_* ports read as zero.
`timescale 1ns/1ps

package my_struct_s;
  typedef struct packed {
    logic [15:0] src_id;
    logic [15:0] dst_id;
  } tuple_t;

  typedef struct packed {
    tuple_t      tuple;
    logic [15:0] meta;
  } fce_t;
endpackage

module pq_op_sched
  import my_struct_s::*;
#(
  parameter int PQ_DEPTH  = 8,
  parameter int PQ_AWIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  // enqueue requester
  input  logic                enq_req,
  output logic                enq_ack,
  input  fce_t                enq_fce,
  // dequeue requester
  input  logic                deq_req,
  output logic                deq_ack,
  output fce_t                deq_fce,
  // read-modify-write requester
  input  logic                rmw_req,
  output logic                rmw_ack,
  input  tuple_t              rmw_tuple,
  input  logic                rmw_del,
  input  fce_t                rmw_fce,
  output logic                rmw_done,
  output logic                rmw_hit,
  output fce_t                rmw_old_fce,
  output logic                err_multi_hit,
  // queue command port
  output logic                q_enq,
  output logic                q_deq,
  output logic                q_lookup,
  output logic                q_update,
  output logic                q_delete,
  output fce_t                q_enq_fce,
  output fce_t                q_update_fce,
  output tuple_t              q_lookup_tuple,
  output logic [PQ_DEPTH-1:0] q_update_bitmap,
  output logic [PQ_DEPTH-1:0] q_delete_bitmap,
  // queue status / lookup result
  input  logic                q_full,
  input  logic                q_empty,
  input  logic                q_hit,
  input  logic                q_hit_valid,
  input  logic [PQ_DEPTH-1:0] q_hit_bitmap,
  input  fce_t                q_hit_fce,
  input  fce_t                q_deq_fce,
  // operation counters
  output logic [15:0]         stat_enq,
  output logic [15:0]         stat_deq,
  output logic [15:0]         stat_rmw,
  output logic [15:0]         stat_miss
);

  typedef enum logic [1:0] {ST_IDLE, ST_LKWAIT, ST_CHECK} state_t;
  typedef enum logic [1:0] {RR_ENQ, RR_DEQ, RR_RMW} rr_t;

  localparam logic [PQ_AWIDTH:0] CNT_ONE = 1;

  state_t              state_reg;
  rr_t                 rr_ptr_reg;
  rr_t                 rr_ptr_next;
  logic                rmw_del_reg;
  fce_t                rmw_fce_reg;
  logic                rmw_done_reg;
  logic                rmw_hit_reg;
  logic                q_update_reg;
  logic                q_delete_reg;
  logic                err_multi_hit_reg;
  fce_t                rmw_old_fce_reg;
  logic [PQ_DEPTH-1:0] commit_bitmap_reg;

  logic idle_ok;
  logic elig_enq, elig_deq, elig_rmw;
  logic grant_enq, grant_deq, grant_rmw;
  logic hit_one, hit_multi;

  // Grants only come from IDLE and never while reset is asserted.
  assign idle_ok  = rst_n && (state_reg == ST_IDLE);
  assign elig_enq = idle_ok && enq_req && !q_full;
  assign elig_deq = idle_ok && deq_req && !q_empty;
  assign elig_rmw = idle_ok && rmw_req;

  // Population count of the hit bitmap as a ripple of small adders.
  logic [PQ_AWIDTH:0] cnt_chain [PQ_DEPTH+1];
  assign cnt_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < PQ_DEPTH; gi++) begin : g_hit_cnt
      assign cnt_chain[gi+1] = cnt_chain[gi] + {{PQ_AWIDTH{1'b0}}, q_hit_bitmap[gi]};
    end
  endgenerate

  assign hit_one   = q_hit && (cnt_chain[PQ_DEPTH] == CNT_ONE);
  assign hit_multi = q_hit && (cnt_chain[PQ_DEPTH] > CNT_ONE);

  // Round-robin pick starting at the pointer; pointer moves past the winner.
  always_comb begin
    grant_enq   = 1'b0;
    grant_deq   = 1'b0;
    grant_rmw   = 1'b0;
    rr_ptr_next = rr_ptr_reg;
    case (rr_ptr_reg)
      RR_DEQ: begin
        if (elig_deq)      grant_deq = 1'b1;
        else if (elig_rmw) grant_rmw = 1'b1;
        else if (elig_enq) grant_enq = 1'b1;
      end
      RR_RMW: begin
        if (elig_rmw)      grant_rmw = 1'b1;
        else if (elig_enq) grant_enq = 1'b1;
        else if (elig_deq) grant_deq = 1'b1;
      end
      default: begin
        if (elig_enq)      grant_enq = 1'b1;
        else if (elig_deq) grant_deq = 1'b1;
        else if (elig_rmw) grant_rmw = 1'b1;
      end
    endcase
    if (grant_enq)      rr_ptr_next = RR_DEQ;
    else if (grant_deq) rr_ptr_next = RR_RMW;
    else if (grant_rmw) rr_ptr_next = RR_ENQ;
  end

  // RMW sequencer: capture request, wait for lookup, register commit outputs for CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      rr_ptr_reg        <= RR_ENQ;
      rmw_del_reg       <= 1'b0;
      rmw_fce_reg       <= '0;
      rmw_done_reg      <= 1'b0;
      rmw_hit_reg       <= 1'b0;
      q_update_reg      <= 1'b0;
      q_delete_reg      <= 1'b0;
      err_multi_hit_reg <= 1'b0;
      rmw_old_fce_reg   <= '0;
      commit_bitmap_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      case (state_reg)
        ST_IDLE: begin
          if (grant_rmw) begin
            rmw_del_reg <= rmw_del;
            rmw_fce_reg <= rmw_fce;
            state_reg   <= ST_LKWAIT;
          end
        end
        ST_LKWAIT: begin
          if (q_hit_valid) begin
            rmw_done_reg      <= 1'b1;
            rmw_hit_reg       <= hit_one;
            q_update_reg      <= hit_one && !rmw_del_reg;
            q_delete_reg      <= hit_one && rmw_del_reg;
            commit_bitmap_reg <= hit_one ? q_hit_bitmap : '0;
            rmw_old_fce_reg   <= q_hit_fce;
            if (hit_multi) err_multi_hit_reg <= 1'b1;
            state_reg         <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          rmw_done_reg      <= 1'b0;
          rmw_hit_reg       <= 1'b0;
          q_update_reg      <= 1'b0;
          q_delete_reg      <= 1'b0;
          commit_bitmap_reg <= '0;
          state_reg         <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign enq_ack         = grant_enq;
  assign q_enq           = grant_enq;
  assign q_enq_fce       = enq_fce;
  assign deq_ack         = grant_deq;
  assign q_deq           = grant_deq;
  assign deq_fce         = q_deq_fce;
  assign rmw_ack         = grant_rmw;
  assign q_lookup        = grant_rmw;
  assign q_lookup_tuple  = rmw_tuple;
  assign q_update        = q_update_reg;
  assign q_delete        = q_delete_reg;
  assign q_update_fce    = rmw_fce_reg;
  assign q_update_bitmap = commit_bitmap_reg;
  assign q_delete_bitmap = commit_bitmap_reg;
  assign rmw_done        = rmw_done_reg;
  assign rmw_hit         = rmw_hit_reg;
  assign rmw_old_fce     = rmw_old_fce_reg;
  assign err_multi_hit   = err_multi_hit_reg;

`ifdef PQ_SCHED_STATS_EN
  // Event order: enq, deq, rmw completion, rmw miss.
  logic [3:0] stat_inc;
  assign stat_inc = {rmw_done_reg && !rmw_hit_reg, rmw_done_reg, grant_deq, grant_enq};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      // Saturating event counter.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign stat_enq  = g_stat[0].cnt_reg;
  assign stat_deq  = g_stat[1].cnt_reg;
  assign stat_rmw  = g_stat[2].cnt_reg;
  assign stat_miss = g_stat[3].cnt_reg;
`else
  assign stat_enq  = '0;
  assign stat_deq  = '0;
  assign stat_rmw  = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_pq_op_sched.sv
// Bench for pq_op_sched: grant table, hand-written RMW/reset sequences and
// a randomized run against a rotating-priority-list reference model.
`timescale 1ns/1ps

module tb_pq_op_sched;
  import my_struct_s::*;

`ifdef PQ_SCHED_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enq_req, enq_ack, deq_req, deq_ack, rmw_req, rmw_ack, rmw_del;
  logic       rmw_done, rmw_hit, err_multi_hit;
  logic       q_enq, q_deq, q_lookup, q_update, q_delete;
  logic       q_full, q_empty, q_hit, q_hit_valid;
  logic [7:0] q_update_bitmap, q_delete_bitmap, q_hit_bitmap;
  fce_t       enq_fce, deq_fce, rmw_fce, rmw_old_fce, q_enq_fce, q_update_fce, q_hit_fce, q_deq_fce;
  tuple_t     rmw_tuple, q_lookup_tuple;
  logic [15:0] stat_enq, stat_deq, stat_rmw, stat_miss;

  pq_op_sched #(.PQ_DEPTH(8), .PQ_AWIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_req(enq_req), .enq_ack(enq_ack), .enq_fce(enq_fce),
    .deq_req(deq_req), .deq_ack(deq_ack), .deq_fce(deq_fce),
    .rmw_req(rmw_req), .rmw_ack(rmw_ack), .rmw_tuple(rmw_tuple), .rmw_del(rmw_del),
    .rmw_fce(rmw_fce), .rmw_done(rmw_done), .rmw_hit(rmw_hit), .rmw_old_fce(rmw_old_fce),
    .err_multi_hit(err_multi_hit),
    .q_enq(q_enq), .q_deq(q_deq), .q_lookup(q_lookup), .q_update(q_update), .q_delete(q_delete),
    .q_enq_fce(q_enq_fce), .q_update_fce(q_update_fce), .q_lookup_tuple(q_lookup_tuple),
    .q_update_bitmap(q_update_bitmap), .q_delete_bitmap(q_delete_bitmap),
    .q_full(q_full), .q_empty(q_empty), .q_hit(q_hit), .q_hit_valid(q_hit_valid),
    .q_hit_bitmap(q_hit_bitmap), .q_hit_fce(q_hit_fce), .q_deq_fce(q_deq_fce),
    .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_rmw(stat_rmw), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // reference model state
  int   m_order[$];
  int   m_phase;      // 0 idle, 1 waiting for lookup, 2 result cycle
  bit   m_del, m_err, r_hit, r_del;
  fce_t m_fce, r_old;
  logic [7:0] r_bm;
  int   m_cnt[4];
  int   last_g;

  typedef struct {
    bit enq, deq, full, empty, e_enq, e_deq;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] flags();
    return {enq_ack, q_enq, deq_ack, q_deq, rmw_ack, q_lookup, q_update, q_delete, rmw_done, rmw_hit};
  endfunction

  function automatic logic [9:0] mk(input bit e, d, r, u, x, dn, h);
    return {e, e, d, d, r, r, u, x, dn, h};
  endfunction

  function automatic logic [63:0] exp_stat(input int v);
    return STATS_EN ? 64'(v) : 64'd0;
  endfunction

  function automatic fce_t rnd_fce();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_flags(input string nm, input bit e, d, r, u, x, dn, h);
    #1;
    chk(nm, flags(), mk(e, d, r, u, x, dn, h));
  endtask

  task automatic idle_inputs();
    enq_req = 0; deq_req = 0; rmw_req = 0; rmw_del = 0;
    q_full = 0; q_empty = 0; q_hit = 0; q_hit_valid = 0; q_hit_bitmap = '0;
  endtask

  task automatic chk_stats(input string nm, input int e0, e1, e2, e3);
    chk({nm, "_stat_enq"}, stat_enq, exp_stat(e0));
    chk({nm, "_stat_deq"}, stat_deq, exp_stat(e1));
    chk({nm, "_stat_rmw"}, stat_rmw, exp_stat(e2));
    chk({nm, "_stat_miss"}, stat_miss, exp_stat(e3));
  endtask

  // Reset with a live enq request: nothing may be granted while rst_n is low.
  task automatic do_reset();
    step();
    idle_inputs();
    enq_req = 1;
    rst_n = 0;
    #1;
    chk("reset_flags", flags(), 10'd0);
    chk("reset_err", err_multi_hit, 0);
    chk("reset_old_fce", rmw_old_fce, 0);
    chk_stats("reset", 0, 0, 0, 0);
    step();
    rst_n = 1;
    enq_req = 0;
    m_order = '{0, 1, 2};
    m_phase = 0; m_err = 0; last_g = -1;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // One RMW: grant, optional lookup wait cycles, result, commit, idle.
  task automatic run_rmw(input string nm, input bit del, input bit hit, input logic [7:0] bm,
                         input int waits, input bit e_hit);
    tuple_t t;
    fce_t   f, old;
    t = tuple_t'($urandom); f = rnd_fce(); old = rnd_fce();
    step();
    rmw_req = 1; rmw_del = del; rmw_tuple = t; rmw_fce = f;
    expect_flags({nm, "_grant"}, 0, 0, 1, 0, 0, 0, 0);
    chk({nm, "_tuple"}, q_lookup_tuple, t);
    for (int w = 0; w < waits; w++) begin
      step();
      rmw_req = 0; q_hit_valid = 0;
      expect_flags({nm, "_wait"}, 0, 0, 0, 0, 0, 0, 0);
    end
    step();
    rmw_req = 0; q_hit_valid = 1; q_hit = hit; q_hit_bitmap = bm; q_hit_fce = old;
    expect_flags({nm, "_lkwait"}, 0, 0, 0, 0, 0, 0, 0);
    step();
    q_hit_valid = 0; q_hit = 0; q_hit_bitmap = '0;
    expect_flags({nm, "_check"}, 0, 0, 0, e_hit && !del, e_hit && del, 1, e_hit);
    chk({nm, "_old_fce"}, rmw_old_fce, old);
    if (e_hit && !del) begin
      chk({nm, "_upd_bitmap"}, q_update_bitmap, bm);
      chk({nm, "_upd_fce"}, q_update_fce, f);
    end
    if (e_hit && del) chk({nm, "_del_bitmap"}, q_delete_bitmap, bm);
    step();
    expect_flags({nm, "_idle"}, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int g, idx, kind, a;
  bit el, e_enq, e_deq, e_rmw, e_upd, e_dele, e_done, e_hit;

  initial begin
    rst_n = 1;
    idle_inputs();
    enq_fce = '0; rmw_fce = '0; rmw_tuple = '0; q_hit_fce = '0; q_deq_fce = '0;

    // ---------------- grant table from reset (pointer at enq) ----------------
    tbl[0]  = '{1, 1, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 1, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 1};
    tbl[6]  = '{1, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step();
      enq_req = tbl[i].enq; deq_req = tbl[i].deq; q_full = tbl[i].full; q_empty = tbl[i].empty;
      enq_fce = rnd_fce(); q_deq_fce = rnd_fce();
      expect_flags($sformatf("tbl_row%0d", i), tbl[i].e_enq, tbl[i].e_deq, 0, 0, 0, 0, 0);
      if (tbl[i].e_enq) chk($sformatf("tbl_enq_fce%0d", i), q_enq_fce, enq_fce);
      if (tbl[i].e_deq) chk($sformatf("tbl_deq_fce%0d", i), deq_fce, q_deq_fce);
    end

    // ---------------- fill to full: 8 enqueues then blocked ----------------
    do_reset();
    enq_fce = rnd_fce();
    for (int i = 0; i < 11; i++) begin
      step();
      enq_req = 1; q_full = (i >= 8);
      expect_flags($sformatf("fill_cyc%0d", i), i < 8, 0, 0, 0, 0, 0, 0);
      if (i < 8) chk($sformatf("fill_fce%0d", i), q_enq_fce, enq_fce);
    end
    idle_inputs();

    // ---------------- all three requesting ----------------
    do_reset();
    step();
    enq_req = 1; deq_req = 1; rmw_req = 1; rmw_del = 0; rmw_tuple = tuple_t'($urandom);
    expect_flags("rr_c0_enq", 1, 0, 0, 0, 0, 0, 0);
    step(); expect_flags("rr_c1_deq", 0, 1, 0, 0, 0, 0, 0);
    step(); expect_flags("rr_c2_rmw", 0, 0, 1, 0, 0, 0, 0);
    step();
    rmw_req = 0; q_hit_valid = 1; q_hit = 0; q_hit_bitmap = '0;
    expect_flags("rr_c3_lkwait", 0, 0, 0, 0, 0, 0, 0);
    step();
    q_hit_valid = 0;
    expect_flags("rr_c4_check", 0, 0, 0, 0, 0, 1, 0);
    step(); expect_flags("rr_c5_enq", 1, 0, 0, 0, 0, 0, 0);
    step(); idle_inputs();

    // ---------------- RMW outcomes ----------------
    do_reset();
    run_rmw("upd_e2", 0, 1, 8'h04, 0, 1);
    chk_stats("upd_e2", 0, 0, 1, 0);
    run_rmw("del_e5", 1, 1, 8'h20, 2, 1);
    run_rmw("miss", 0, 0, 8'h00, 1, 0);
    chk_stats("miss", 0, 0, 3, 1);
    chk("err_before_multi", err_multi_hit, 0);
    run_rmw("multi", 0, 1, 8'h11, 0, 0);
    chk("err_after_multi", err_multi_hit, 1);
    step(); step(); step();
    #1 chk("err_sticky", err_multi_hit, 1);
    chk_stats("multi", 0, 0, 4, 2);

    // ---------------- reset in LKWAIT ----------------
    step();
    rmw_req = 1; rmw_del = 0;
    expect_flags("rst_rmw_grant", 0, 0, 1, 0, 0, 0, 0);
    step();
    rmw_req = 0; rst_n = 0;
    #1;
    chk("rst_lkwait_flags", flags(), 10'd0);
    chk("rst_lkwait_err", err_multi_hit, 0);
    chk("rst_lkwait_old", rmw_old_fce, 0);
    step();
    rst_n = 1; q_hit_valid = 1; q_hit = 1; q_hit_bitmap = 8'h01; enq_req = 1; q_full = 0;
    expect_flags("rst_idle_enq", 1, 0, 0, 0, 0, 0, 0);
    step();
    enq_req = 0; q_hit_valid = 0;
    expect_flags("rst_no_done", 0, 0, 0, 0, 0, 0, 0);
    step();
    deq_req = 1; q_empty = 1;
    expect_flags("deq_empty0", 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_flags("deq_empty1", 0, 0, 0, 0, 0, 0, 0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (last_g == 0) enq_req = 0;
      if (last_g == 1) deq_req = 0;
      if (last_g == 2) rmw_req = 0;
      if (!enq_req && $urandom_range(1, 0) == 1) begin enq_req = 1; enq_fce = rnd_fce(); end
      if (!deq_req && $urandom_range(1, 0) == 1) deq_req = 1;
      if (!rmw_req && $urandom_range(3, 0) == 0) begin
        rmw_req = 1; rmw_del = $urandom_range(1, 0) == 1;
        rmw_tuple = tuple_t'($urandom); rmw_fce = rnd_fce();
      end
      q_full = ($urandom_range(3, 0) == 0);
      q_empty = ($urandom_range(3, 0) == 0);
      q_deq_fce = rnd_fce();
      q_hit_valid = $urandom_range(1, 0) == 1;
      q_hit_fce = rnd_fce();
      kind = $urandom_range(63, 0);
      a = $urandom_range(7, 0);
      q_hit_bitmap = '0;
      if (kind == 0) begin
        q_hit = 1; q_hit_bitmap[a] = 1'b1; q_hit_bitmap[(a + 1 + $urandom_range(6, 0)) % 8] = 1'b1;
      end else if (kind < 24) begin
        q_hit = 0;
      end else begin
        q_hit = 1; q_hit_bitmap[a] = 1'b1;
      end
      #1;
      // model prediction for this cycle
      g = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < 3; k++) begin
          idx = m_order[k];
          el = (idx == 0) ? (enq_req && !q_full) : (idx == 1) ? (deq_req && !q_empty) : rmw_req;
          if (g < 0 && el) g = idx;
        end
      end
      e_enq = (g == 0); e_deq = (g == 1); e_rmw = (g == 2);
      e_done = (m_phase == 2); e_hit = e_done && r_hit;
      e_upd = e_hit && !r_del; e_dele = e_hit && r_del;
      chk("rand_flags", flags(), mk(e_enq, e_deq, e_rmw, e_upd, e_dele, e_done, e_hit));
      if (e_enq) chk("rand_enq_fce", q_enq_fce, enq_fce);
      if (e_deq) chk("rand_deq_fce", deq_fce, q_deq_fce);
      if (e_rmw) chk("rand_tuple", q_lookup_tuple, rmw_tuple);
      if (e_done) chk("rand_old_fce", rmw_old_fce, r_old);
      if (e_upd) begin
        chk("rand_upd_bitmap", q_update_bitmap, r_bm);
        chk("rand_upd_fce", q_update_fce, m_fce);
      end
      if (e_dele) chk("rand_del_bitmap", q_delete_bitmap, r_bm);
      chk("rand_err", err_multi_hit, m_err);
      chk_stats("rand", m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
      // model update at the clock edge
      last_g = g;
      if (m_phase == 0) begin
        if (g >= 0) begin
          while (m_order[$] != g) m_order.push_back(m_order.pop_front());
          if (g < 2) m_cnt[g]++;
          if (g == 2) begin
            m_phase = 1; m_del = rmw_del; m_fce = rmw_fce;
          end
        end
      end else if (m_phase == 1) begin
        if (q_hit_valid) begin
          r_hit = q_hit && ($countones(q_hit_bitmap) == 1);
          if (q_hit && $countones(q_hit_bitmap) > 1) m_err = 1;
          r_del = m_del; r_bm = q_hit_bitmap; r_old = q_hit_fce;
          m_phase = 2;
        end
      end else begin
        m_cnt[2]++;
        if (!r_hit) m_cnt[3]++;
        m_phase = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pq_op_sched.md
PQ_OP_SCHED -- requirements
Module: pq_op_sched

Interface
REQ-001 Parameters: PQ_DEPTH, 8, queue entry count; PQ_AWIDTH, 3, log2(PQ_DEPTH); fce_t and tuple_t come from my_struct_s.sv.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 enq_req / enq_ack  in / out  1 / 1  enqueue handshake; enq_fce  in  fce_t  entry to enqueue.
REQ-005 deq_req / deq_ack  in / out  1 / 1  dequeue handshake; deq_fce  out  fce_t  head entry, valid with deq_ack.
REQ-006 rmw_req / rmw_ack  in / out  1 / 1  read-modify-write handshake; rmw_tuple  in  tuple_t  lookup key; rmw_del  in  1  1=delete, 0=update; rmw_fce  in  fce_t  update value.
REQ-007 rmw_done / rmw_hit  out  1 / 1  RMW completion pulse and hit result; rmw_old_fce  out  fce_t  pre-update entry.
REQ-008 err_multi_hit  out  1  sticky: lookup matched more than one entry.
REQ-009 q_enq / q_deq / q_lookup / q_update / q_delete  out  1 each  single-cycle queue command strobes.
REQ-010 q_enq_fce / q_update_fce  out  fce_t; q_lookup_tuple  out  tuple_t; q_update_bitmap / q_delete_bitmap  out  PQ_DEPTH  target entry.
REQ-011 q_full, q_empty, q_hit, q_hit_valid  in  1; q_hit_bitmap  in  PQ_DEPTH; q_hit_fce, q_deq_fce  in  fce_t.
REQ-012 stat_enq, stat_deq, stat_rmw, stat_miss  out  16 each  operation counters.

Function
REQ-013 At most one q_* strobe asserted per cycle; no strobe asserted while state != IDLE except the commit strobe in CHECK.
REQ-014 States: IDLE, LKWAIT, CHECK; IDLE on reset.
REQ-015 IDLE: eligible requesters are enq (enq_req && !q_full), deq (deq_req && !q_empty), rmw (rmw_req); round-robin order enq->deq->rmw, pointer advances to the requester after the one granted.
REQ-016 Enq/deq grant is combinational in the grant cycle: q_enq with q_enq_fce=enq_fce and enq_ack, or q_deq and deq_ack with deq_fce=q_deq_fce; state stays IDLE; one op per cycle sustained.
REQ-017 Rmw grant cycle N: q_lookup=1, q_lookup_tuple=rmw_tuple, rmw_ack=1; rmw_del and rmw_fce captured; next state LKWAIT.
REQ-018 LKWAIT (N+1): when q_hit_valid=1, capture q_hit, q_hit_bitmap, q_hit_fce and go to CHECK; otherwise hold in LKWAIT, no other grants.
REQ-019 CHECK (N+2): a one-hot bitmap with hit asserts q_delete (bitmap) if rmw_del, otherwise q_update (bitmap, captured rmw_fce); rmw_done=1, rmw_hit=1, rmw_old_fce=captured q_hit_fce; next IDLE.
REQ-020 CHECK with miss: no strobe; rmw_done=1, rmw_hit=0.
REQ-021 CHECK with multi-bit bitmap: no strobe; rmw_done=1, rmw_hit=0, err_multi_hit set until reset.
REQ-022 A requester holds req and data stable until its ack; enq is never granted while q_full=1 and deq never while q_empty=1.
REQ-023 Counters increment on enq_ack, deq_ack, rmw_done and rmw_done&&!rmw_hit; saturate at 0xFFFF.

Reset
REQ-024 rst_n low asynchronously forces IDLE, RR pointer=enq, all strobes/acks/done=0, rmw_hit=0, rmw_old_fce=0, err_multi_hit=0, counters=0.
REQ-025 Reset mid-RMW aborts it with no rmw_done and no commit strobe.

Configuration
REQ-026 Macro PQ_SCHED_STATS_EN: defined, counters per REQ-023; undefined, the stat_* ports remain and are tied to 0 with no counter flops.

Verification
REQ-027 Empty queue, enq_req with tuple A for 8 cycles -> 8 consecutive enq_ack/q_enq; then q_full=1 and enq_ack=0.
REQ-028 enq_req, deq_req, rmw_req held together -> grants in order enq, deq, rmw; then the rmw completes in CHECK before the next enq grant.
REQ-029 RMW update on tuple at entry 2 (bitmap 0x04) -> q_lookup at N, q_update with bitmap 0x04 at N+2, rmw_done and rmw_hit=1, rmw_old_fce=old entry.
REQ-030 RMW on absent tuple -> rmw_done, rmw_hit=0, no q_update/q_delete, stat_miss+1.
REQ-031 Hit bitmap 0x11 -> no commit, err_multi_hit=1 held until rst_n low.
REQ-032 rst_n pulsed low in LKWAIT -> immediate IDLE, no rmw_done; deq_req with q_empty=1 -> no deq_ack.
